// File: rtl/sub_pkg.sv
// Shared types and limits for the bit-serial subtractor.
package sub_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} sub_state_t;

   // Widest operand the counter/shift-register sizing is meant for.
   localparam int MAX_N = 32;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out.
module full_subtractor (
   output logic d,
   output logic bout,
   input  logic a,
   input  logic b,
   input  logic bin
);

   assign d    = a ^ b ^ bin;
   // Borrow when b exceeds a, or when a==b and a borrow is already pending.
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor D = A - B, LSB first, one bit per clock.
// Operands are captured on an accepted start and shifted through a single
// full-subtractor cell; the difference is assembled MSB-side into D.
module serial_subtractor
   import sub_pkg::*;
#(
   parameter int N = 8   // 1..MAX_N
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] D,
   output logic         BORROW
);

   localparam int CW = $clog2(N) + 1;

   sub_state_t    state, state_nxt;
   logic [N-1:0]  a_sr, b_sr, d_reg, d_shift;
   logic [CW-1:0] cnt;
   logic          borrow_ff, bo_reg;
   logic          fs_d, fs_bout;
   logic          last_bit, load;

   full_subtractor u_fs (
      .d    (fs_d),
      .bout (fs_bout),
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .bin  (borrow_ff)
   );

   // New result bit enters at the top; a 1-bit build has nothing to shift.
   generate
      if (N == 1) begin : g_d1
         assign d_shift = fs_d;
      end else begin : g_dn
         assign d_shift = {fs_d, d_reg[N-1:1]};
      end
   endgenerate

   assign last_bit = (cnt == CW'(N - 1));
   // start only counts when not mid-operation (IDLE or DONE).
   assign load     = start && (state != SHIFT);

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = start ? SHIFT : IDLE;
         SHIFT:   state_nxt = last_bit ? DONE : SHIFT;
         DONE:    state_nxt = start ? SHIFT : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State, operand shift registers, borrow chain and result registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         a_sr      <= '0;
         b_sr      <= '0;
         d_reg     <= '0;
         cnt       <= '0;
         borrow_ff <= 1'b0;
         bo_reg    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (load) begin
            a_sr      <= A;
            b_sr      <= B;
            borrow_ff <= 1'b0;
            cnt       <= '0;
         end else if (state == SHIFT) begin
            d_reg     <= d_shift;
            a_sr      <= a_sr >> 1;
            b_sr      <= b_sr >> 1;
            borrow_ff <= fs_bout;
            // Counter parks at N-1 on the last bit instead of wrapping.
            if (last_bit) bo_reg <= fs_bout;
            else          cnt    <= cnt + CW'(1);
         end
      end
   end

   assign busy   = (state == SHIFT);
   assign done   = (state == DONE);
   assign D      = d_reg;
   assign BORROW = bo_reg;

endmodule
